// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, default width.
package muldiv_unit_pkg;

  localparam int unsigned MD_WIDTH = 32;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// EX-stage request/response bundle between the pipeline and the multiply/divide unit.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             valid;
  logic [2:0]       md_op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Pipeline side: issues ops, observes HI/LO and the stall request.
  modport master (
    output valid, md_op, A, B, cancel,
    input  busy, done, hi, lo
  );

  // Unit side.
  modport slave (
    input  valid, md_op, A, B, cancel,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_core.sv
// Iterative datapath: shift-add multiply and restoring divide on magnitudes,
// with the sign fix-up applied combinationally to the final accumulator.
module muldiv_core
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,      // latch operands (start of op)
  input  logic             step_i,      // perform one iteration
  input  logic             is_div_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] res_hi_o,
  output logic [WIDTH-1:0] res_lo_o
);

  // acc holds {partial, multiplier} for mult and {remainder, dividend/quotient} for div.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;  // multiplicand or divisor magnitude
  logic               is_div_q, is_div_d;
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;

  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh, rem_diff;
  logic [2*WIDTH-1:0] div_next;

  // Operand magnitudes, one iteration of each algorithm, and next-state selection.
  always_comb begin
    a_abs = (is_signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    b_abs = (is_signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opnd_q};
    // Restore on borrow: keep the shifted remainder and shift in a 0.
    div_next = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                               : {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    if (load_i) begin
      acc_d    = {{WIDTH{1'b0}}, (is_div_i ? a_abs : b_abs)};
      opnd_d   = is_div_i ? b_abs : a_abs;
      is_div_d = is_div_i;
      neg_a_d  = is_signed_i & a_i[WIDTH-1];
      neg_b_d  = is_signed_i & b_i[WIDTH-1];
    end else if (step_i) begin
      acc_d = is_div_q ? div_next : mul_next;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
    end
  end

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  logic               neg_res, div_zero;

  // Sign fix-up. Divide-by-zero leaves the quotient all-ones; the remainder path
  // then reproduces A exactly because rem == |A| and takes A's sign.
  always_comb begin
    neg_res  = neg_a_q ^ neg_b_q;
    div_zero = (opnd_q == '0);
    prod     = neg_res ? -acc_q : acc_q;
    quo      = acc_q[WIDTH-1:0];
    rem      = acc_q[2*WIDTH-1:WIDTH];
    if (is_div_q) begin
      res_lo_o = div_zero ? '1 : (neg_res ? -quo : quo);
      res_hi_o = neg_a_q ? -rem : rem;
    end else begin
      res_lo_o = prod[WIDTH-1:0];
      res_hi_o = prod[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Stalls EX through busy; cancel squashes an in-flight op without touching HI/LO.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_unit_if.slave  bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  md_state_e        state_q, state_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             is_md, is_div, is_signed, idle, start;
  logic [WIDTH-1:0] res_hi, res_lo;

  // Request decode; new requests are only accepted in IDLE and never alongside cancel.
  always_comb begin
    is_md     = (bus.md_op == MD_MULT) || (bus.md_op == MD_MULTU) ||
                (bus.md_op == MD_DIV)  || (bus.md_op == MD_DIVU);
    is_div    = (bus.md_op == MD_DIV)  || (bus.md_op == MD_DIVU);
    is_signed = (bus.md_op == MD_MULT) || (bus.md_op == MD_DIV);
    idle      = (state_q == S_IDLE);
    start     = idle && bus.valid && is_md && !bus.cancel;
  end

  muldiv_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (start),
    .step_i      (state_q == S_CALC),
    .is_div_i    (is_div),
    .is_signed_i (is_signed),
    .a_i         (bus.A),
    .b_i         (bus.B),
    .res_hi_o    (res_hi),
    .res_lo_o    (res_lo)
  );

  // FSM next state, iteration counter, HI/LO writes and done pulse.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    if (bus.cancel) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_CALC;
            count_d = '0;
          end else if (bus.valid && bus.md_op == MD_MTHI) begin
            hi_d = bus.A;
          end else if (bus.valid && bus.md_op == MD_MTLO) begin
            lo_d = bus.A;
          end
        end
        S_CALC: begin
          count_d = count_q + 1'b1;
          if (count_q == CntW'(WIDTH - 1)) begin
            state_d = S_FIX;
          end
        end
        S_FIX: begin
          hi_d    = res_hi;
          lo_d    = res_lo;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Control and architectural state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected {hi,lo} per MULT/DIV op,
// a monitor pops and compares on every done pulse.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clk;
  logic rst_n;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(
    .WIDTH (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  logic [63:0] exp_q[$];
  string       name_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_done: got done with hi=%08h lo=%08h, expected none", bus.hi, bus.lo);
      end else begin
        logic [63:0] e;
        string       nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check({nm, "_hi"}, bus.hi, e[63:32]);
        check({nm, "_lo"}, bus.lo, e[31:0]);
      end
    end
  end

  // Present a request for exactly one edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.valid = 1'b1;
    bus.md_op = op;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    bus.md_op = MD_NONE;
  endtask

  // Full MULT/DIV transaction: push expectation, issue, measure busy length.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e_hi, input logic [31:0] e_lo);
    int cycles;
    exp_q.push_back({e_hi, e_lo});
    name_q.push_back(name);
    issue(op, a, b);
    cycles = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) break;
      cycles++;
    end
    check({name, "_busy_cycles"}, 32'(cycles), 32'd33);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int done_before;
    logic [31:0] hi_keep, lo_keep;

    rst_n      = 1'b0;
    bus.valid  = 1'b0;
    bus.md_op  = MD_NONE;
    bus.A      = '0;
    bus.B      = '0;
    bus.cancel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hi", bus.hi, 32'h0);
    check("reset_lo", bus.lo, 32'h0);
    check("reset_busy", {31'b0, bus.busy}, 32'h0);
    check("reset_done", {31'b0, bus.done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("mult_neg3x7",   MD_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("multu_max",     MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_pos_neg",  MD_MULT,  32'h1234_5678, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hDB97_5310);
    run_op("div_neg7_2",    MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_neg2",    MD_DIV,   32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu_7_2",      MD_DIVU,  32'd7,        32'd2,        32'h0000_0001, 32'h0000_0003);
    run_op("divu_100_7",    MD_DIVU,  32'd100,      32'd7,        32'h0000_0002, 32'h0000_000E);
    run_op("div_5_by0",     MD_DIV,   32'd5,        32'd0,        32'h0000_0005, 32'hFFFF_FFFF);
    run_op("div_neg5_by0",  MD_DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op("div_min_neg1",  MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

    // MTHI while busy is ignored; HI ends up holding the product.
    exp_q.push_back({32'h0000_0001, 32'h0000_0000});
    name_q.push_back("multu_mthi_busy");
    issue(MD_MULTU, 32'h0001_0000, 32'h0001_0000);
    repeat (4) @(posedge clk);
    issue(MD_MTHI, 32'h0000_1234, 32'h0);
    for (int i = 0; i < 60 && bus.busy === 1'b1; i++) @(negedge clk);
    check("mthi_busy_drain", {31'b0, bus.busy}, 32'h0);
    @(posedge clk);
    #1;
    check("mthi_ignored_hi", bus.hi, 32'h0000_0001);

    // MTLO in IDLE writes LO at that edge without stalling.
    issue(MD_MTLO, 32'h0000_0055, 32'h0);
    check("mtlo_lo", bus.lo, 32'h0000_0055);
    check("mtlo_busy", {31'b0, bus.busy}, 32'h0);
    check("mtlo_hi_kept", bus.hi, 32'h0000_0001);

    // Cancel mid-CALC: no write, no done.
    hi_keep     = bus.hi;
    lo_keep     = bus.lo;
    done_before = n_done;
    issue(MD_MULT, 32'd2, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    bus.cancel = 1'b1;
    @(posedge clk);
    #1;
    bus.cancel = 1'b0;
    check("cancel_busy", {31'b0, bus.busy}, 32'h0);
    repeat (40) @(posedge clk);
    #1;
    check("cancel_hi", bus.hi, hi_keep);
    check("cancel_lo", bus.lo, lo_keep);
    check("cancel_no_done", 32'(n_done - done_before), 32'h0);

    // Cancel landing on the FIX cycle suppresses the write.
    issue(MD_MULTU, 32'd9, 32'd9);
    repeat (32) @(posedge clk);
    #1;
    bus.cancel = 1'b1;
    @(posedge clk);
    #1;
    bus.cancel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("cancel_fix_lo", bus.lo, lo_keep);
    check("cancel_fix_no_done", 32'(n_done - done_before), 32'h0);

    // Start coincident with cancel is dropped.
    @(negedge clk);
    bus.cancel = 1'b1;
    issue(MD_DIVU, 32'd10, 32'd3);
    bus.cancel = 1'b0;
    check("cancel_start_busy", {31'b0, bus.busy}, 32'h0);

    // Asynchronous reset mid-DIV clears HI/LO and busy immediately.
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_hi", bus.hi, 32'h0);
    check("rst_mid_lo", bus.lo, 32'h0);
    check("rst_mid_busy", {31'b0, bus.busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("rst_no_done", 32'(n_done - done_before), 32'h0);

    // Unit still works after reset.
    run_op("mult_after_rst", MD_MULT, 32'd6, 32'd7, 32'h0, 32'd42);

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    check("total_done", 32'(n_done), 32'd12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
